// File: rtl/uart_rd_sched_if.sv
// Handshake bundle between the UART receive buffers and the read scheduler.
// master = scheduler side, slave = buffer/packer side.
interface uart_rd_sched_if #(
    parameter int NCH   = 5,
    parameter int ADR_W = 5
);
    logic [NCH-1:0]   done;
    logic [NCH-1:0]   rd;
    logic [ADR_W-1:0] rd_adr;
    logic             vld;
    logic [2:0]       ch;
    logic             last;
    logic             busy;
    logic [NCH-1:0]   ovr;

    modport master (
        input  done,
        output rd, rd_adr, vld, ch, last, busy, ovr
    );

    modport slave (
        output done,
        input  rd, rd_adr, vld, ch, last, busy, ovr
    );
endinterface

// File: rtl/uart_rd_sched.sv
// Round-robin read scheduler for the per-channel UART receive buffers.
// Drains one buffer at a time, one byte per rd pulse, on clk80MHz.
module uart_rd_sched #(
    parameter int NCH    = 5,
    parameter int ADR_W  = 5,
    parameter int NBYTES = 8,
    parameter int GAP    = 3
) (
    input logic             clk,
    input logic             rst,
    uart_rd_sched_if.master bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, READ, HOLD, FLUSH} state_t;

    state_t           state;
    state_t           stateNext;
    logic [NCH-1:0]   doneQ;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   clr;
    logic [NCH-1:0]   ovrReg;
    logic [2:0]       ptr;
    logic [2:0]       pick;
    logic [2:0]       chReg;
    logic             found;
    logic             grant;
    logic [ADR_W-1:0] idx;
    logic [GW-1:0]    gapCnt;
    logic             lastByte;
    logic             gapDone;
    logic             vldReg;
    logic             lastReg;
    int               cand;

    assign rise     = bus.done & ~doneQ;
    assign lastByte = (idx == ADR_W'(NBYTES - 1));
    assign gapDone  = (int'(gapCnt) == GAP - 1);
    assign clr      = grant ? (NCH'(1) << pick) : '0;

    // Round-robin search: first pending channel after ptr, with wrap
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NCH) cand = cand - NCH;
            if (!found && pending[cand[CW-1:0]]) begin
                found = 1'b1;
                pick  = 3'(cand);
            end
        end
    end

    // Next-state logic; a grant only happens from IDLE
    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    stateNext = READ;
                    grant     = 1'b1;
                end
            end
            READ: begin
                if (lastByte)      stateNext = FLUSH;
                else if (GAP == 0) stateNext = READ;
                else               stateNext = HOLD;
            end
            HOLD: begin
                if (gapDone) stateNext = READ;
            end
            FLUSH: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Request capture, overrun tracking, byte index and output registers
    always_ff @(posedge clk) begin
        doneQ <= bus.done;
        if (rst) begin
            pending <= '0;
            ovrReg  <= '0;
            ptr     <= 3'(NCH - 1);
            chReg   <= '0;
            idx     <= '0;
            gapCnt  <= '0;
            vldReg  <= 1'b0;
            lastReg <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | rise;
            ovrReg  <= ovrReg | (rise & pending & ~clr);
            vldReg  <= (state == READ);
            lastReg <= (state == READ) && lastByte;
            if (grant) begin
                chReg <= pick;
                ptr   <= pick;
                idx   <= '0;
            end else if (state == READ && !lastByte) begin
                idx <= idx + 1'b1;
            end
            if (state == HOLD) gapCnt <= gapCnt + 1'b1;
            else               gapCnt <= '0;
        end
    end

    assign bus.rd     = (state == READ) ? (NCH'(1) << chReg) : '0;
    assign bus.rd_adr = idx;
    assign bus.vld    = vldReg;
    assign bus.ch     = chReg;
    assign bus.last   = lastReg;
    assign bus.busy   = (state != IDLE);
    assign bus.ovr    = ovrReg;
endmodule
